uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver that consumes the 16x-oversampled baud_tick from the baud generator. It recovers 8N1-style serial frames from the asynchronous rx line, mid-bit sampled. Each byte is presented on a parallel output with a one-cycle valid strobe. It sits between the pad-side rx input and the host-side byte consumer, and pairs with the transmitter on the same baud_tick.

Parameters:
DATA_BITS, 8, data bits per frame (LSB first); legal 5..9
OVERSAMPLE, 16, baud_tick pulses per bit period; must match baud generator; even, >= 8

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
baud_tick  input  1  one-clk pulse, OVERSAMPLE per bit period
rx  input  1  asynchronous serial line, idle high
rx_data  output  DATA_BITS  last received byte; holds until next frame completes
rx_valid  output  1  one-clk pulse: rx_data updated with a good frame
frame_err  output  1  one-clk pulse: stop bit sampled low
rx_busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: asynchronous, active-high. Clock: clk. All state clears immediately on reset.
- Reset values: rx_data=0, rx_valid=0, frame_err=0, rx_busy=0. Synchronizer flops=1 (line idle). State=IDLE. tick_cnt=0, bit_cnt=0.
- rx passes through a 2-flop synchronizer. All decisions use the synchronized value rx_s, which adds 2 clk latency.
- tick_cnt ($clog2(OVERSAMPLE) bits) and bit_cnt ($clog2(DATA_BITS) bits) advance only on clk edges where baud_tick=1. Without baud_tick the FSM holds.
- IDLE: when rx_s=0, go to START with tick_cnt=0. This is evaluated every clk, not only on ticks.
- START: on each tick, tick_cnt++.
  - At tick_cnt==OVERSAMPLE/2-1 (7), if rx_s=0: tick_cnt=0, bit_cnt=0, go to DATA.
  - If rx_s=1 at that point: glitch; return to IDLE and produce no output.
- DATA: on each tick, tick_cnt++.
  - At tick_cnt==OVERSAMPLE-1: shift register <= {rx_s, shreg[DATA_BITS-1:1]} (LSB first), tick_cnt wraps to 0, bit_cnt++.
  - After the DATA_BITS-th sample, go to STOP.
- STOP: at tick_cnt==OVERSAMPLE-1, sample rx_s.
  - If 1: rx_data<=shreg, rx_valid=1 for one clk, go to IDLE.
  - If 0: frame_err=1 for one clk, rx_data unchanged, go to BRK_WAIT.
- BRK_WAIT: stay until rx_s=1, then go to IDLE. This prevents a held-low break from being decoded as repeated 0x00 frames.
- Output latency: rx_valid/frame_err assert on the clk edge after the baud_tick that samples the stop bit. There is no combinational path from rx.
- No back-pressure. The consumer must capture rx_data on rx_valid. Back-to-back frames are legal: a start bit immediately after the stop sample is detected from IDLE with no dead tick.
- rx_valid and frame_err are mutually exclusive and never high more than one consecutive clk.
- Reset mid-frame abandons the frame: no strobe is asserted, and after reset the FSM waits in IDLE for the next falling edge.
- A baud_tick coincident with the IDLE→START transition is not counted. Counting starts on the next tick.

Decomposition:
- Shared package uart_pkg:
  - state enum {IDLE, START, DATA, STOP, BRK_WAIT}
  - localparams MID_TICK=OVERSAMPLE/2-1 and LAST_TICK=OVERSAMPLE-1
  - OVERSAMPLE default, shared with baud_gen and the transmitter
- One sub-module: sync_2ff, a 2-flop synchronizer with reset value parameter (1 here). It is reusable for other async inputs.

Test Plan:
Bench setup: CLK_FREQ=50 MHz, BAUD_RATE=9600, baud_gen instantiated (tick every 325 clk, bit = 5200 clk).
- Send 0x55 with good stop -> exactly one rx_valid pulse, rx_data=0x55, frame_err=0, rx_busy low within 1 tick after stop sample.
- Send 0xA5 then 0x3C back-to-back, no idle gap -> two rx_valid pulses ~52000 clk apart, rx_data=0xA5 then 0x3C.
- Drive rx low for 3 ticks (975 clk), then high -> enters START, returns to IDLE at MID_TICK, no rx_valid, no frame_err.
- Send 0xF0 with stop bit low, then hold rx low 3 bit times, then a good 0x12 -> one frame_err pulse, rx_data stays at prior value, no extra strobes during the break, then rx_valid with 0x12.
- Assert reset during data bit 4 of 0x81, release, then send 0x7E -> outputs all 0 during reset, no strobe for 0x81, rx_valid with rx_data=0x7E.
- DATA_BITS=7 build, send 0x5A (7-bit) -> rx_data=0x5A; stop sampled at bit position 8.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, oversampling defaults and tick helpers
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK_WAIT} state_t;
  localparam int OVERSAMPLE = 16;
  function automatic int mid_tick(input int os);
    return os / 2 - 1;
  endfunction
  function automatic int last_tick(input int os);
    return os - 1;
  endfunction
  localparam int MID_TICK = mid_tick(OVERSAMPLE);
  localparam int LAST_TICK = last_tick(OVERSAMPLE);
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous inputs with configurable reset value
module sync_2ff #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampled 8N1-style UART receiver with mid-bit sampling and break handling
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 rx_busy
);
  import uart_pkg::*;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] MID = TW'(mid_tick(OVERSAMPLE));
  localparam logic [TW-1:0] LAST = TW'(last_tick(OVERSAMPLE));
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("uart_rx: DATA_BITS must be 5..9");
  end
  if (OVERSAMPLE < 8 || OVERSAMPLE % 2 != 0) begin : g_bad_os
    $error("uart_rx: OVERSAMPLE must be even and >= 8");
  end
  logic                 rx_s;
  state_t               state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  sync_2ff #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx),
    .q    (rx_s)
  );
  assign rx_busy = state != IDLE;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE:
          if (!rx_s) begin
            state    <= START;
            tick_cnt <= '0;
          end
        START:
          if (baud_tick) begin
            if (tick_cnt == MID) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= rx_s ? IDLE : DATA;
            end else tick_cnt <= tick_cnt + 1'b1;
          end
        DATA:
          if (baud_tick) begin
            if (tick_cnt == LAST) begin
              tick_cnt <= '0;
              shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) state <= STOP;
            end else tick_cnt <= tick_cnt + 1'b1;
          end
        STOP:
          if (baud_tick) begin
            if (tick_cnt == LAST) begin
              tick_cnt <= '0;
              if (rx_s) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
                state    <= IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= BRK_WAIT;
              end
            end else tick_cnt <= tick_cnt + 1'b1;
          end
        BRK_WAIT:
          if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx (8-bit and 7-bit builds, fast baud tick)
module tb_uart_rx;
  localparam int TD = 4;
  localparam int OS = 16;
  localparam int BIT = TD * OS;
  typedef struct {
    bit         err;
    logic [7:0] data;
  } exp_t;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       baud_tick = 1'b0;
  logic       rx = 1'b1;
  logic       rx7 = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, rx_busy;
  logic [6:0] rx_data7;
  logic       rx_valid7, frame_err7, rx_busy7;
  int         checks = 0;
  int         fails = 0;
  int         n_valid = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         last_valid_cyc = 0;
  int         last_gap = 0;
  int         div = 0;
  bit         prev_strobe = 1'b0;
  logic [7:0] model_data = 8'h00;
  exp_t       exp_q[$];
  exp_t       me;
  logic [6:0] exp7_q[$];
  logic [6:0] me7;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .rx_busy(rx_busy)
  );
  uart_rx #(.DATA_BITS(7), .OVERSAMPLE(OS)) dut7 (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .rx(rx7),
    .rx_data(rx_data7), .rx_valid(rx_valid7), .frame_err(frame_err7), .rx_busy(rx_busy7)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    div <= (div == TD - 1) ? 0 : div + 1;
    baud_tick <= (div == TD - 1);
  end

  always @(negedge clk)
    if (!reset) begin
      if (rx_valid || frame_err) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_strobe: got valid=%b err=%b data=%h, required no strobe", rx_valid, frame_err, rx_data);
        end else begin
          me = exp_q.pop_front();
          checks++;
          if (rx_valid !== !me.err || frame_err !== me.err || rx_data !== me.data) begin
            fails++;
            $display("FAIL strobe: got valid=%b err=%b data=%h, required valid=%b err=%b data=%h",
                     rx_valid, frame_err, rx_data, !me.err, me.err, me.data);
          end
        end
        checks++;
        if (prev_strobe) begin
          fails++;
          $display("FAIL strobe_width: got strobe on consecutive clks, required single-clk pulse");
        end
        if (rx_valid) begin
          n_valid++;
          last_gap = cyc - last_valid_cyc;
          last_valid_cyc = cyc;
        end
        if (frame_err) n_err++;
      end
      prev_strobe = rx_valid || frame_err;
      if (rx_valid7 || frame_err7) begin
        checks++;
        if (frame_err7 || exp7_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_strobe7: got valid=%b err=%b data=%h", rx_valid7, frame_err7, rx_data7);
        end else begin
          me7 = exp7_q.pop_front();
          checks++;
          if (rx_data7 !== me7) begin
            fails++;
            $display("FAIL data7: got %h, required %h", rx_data7, me7);
          end
        end
      end
    end

  task automatic drive_bit(input logic b, input bit to7);
    if (to7) rx7 = b;
    else rx = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [8:0] data, input int nbits, input logic stop, input bit to7);
    drive_bit(1'b0, to7);
    for (int i = 0; i < nbits; i++) drive_bit(data[i], to7);
    drive_bit(stop, to7);
  endtask

  task automatic push_good(input logic [7:0] d);
    exp_q.push_back('{err: 1'b0, data: d});
    model_data = d;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks += 4;
    if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h, required 00", rx_data); end
    if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b, required 0", rx_valid); end
    if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b, required 0", frame_err); end
    if (rx_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, required 0", rx_busy); end
    checks += 2;
    if (rx_data7 !== 7'h00) begin fails++; $display("FAIL reset_data7: got %h, required 00", rx_data7); end
    if (rx_busy7 !== 1'b0) begin fails++; $display("FAIL reset_busy7: got %b, required 0", rx_busy7); end
    reset = 1'b0;
    repeat (BIT) @(negedge clk);
    checks++;
    if (rx_busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b, required 0", rx_busy); end
  endtask

  task automatic test_single;
    int v0;
    v0 = n_valid;
    push_good(8'h55);
    send_frame(9'h055, 8, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    checks += 4;
    if (exp_q.size() != 0) begin fails++; $display("FAIL single_pending: got %0d outstanding, required 0", exp_q.size()); end
    if (n_valid - v0 != 1) begin fails++; $display("FAIL single_count: got %0d pulses, required 1", n_valid - v0); end
    if (rx_data !== 8'h55) begin fails++; $display("FAIL single_data: got %h, required 55", rx_data); end
    if (rx_busy !== 1'b0) begin fails++; $display("FAIL single_busy: got %b, required 0", rx_busy); end
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = n_valid;
    push_good(8'hA5);
    push_good(8'h3C);
    send_frame(9'h0A5, 8, 1'b1, 1'b0);
    send_frame(9'h03C, 8, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    checks += 4;
    if (exp_q.size() != 0) begin fails++; $display("FAIL b2b_pending: got %0d outstanding, required 0", exp_q.size()); end
    if (n_valid - v0 != 2) begin fails++; $display("FAIL b2b_count: got %0d pulses, required 2", n_valid - v0); end
    if (rx_data !== 8'h3C) begin fails++; $display("FAIL b2b_data: got %h, required 3c", rx_data); end
    if (last_gap < 10 * BIT - TD || last_gap > 10 * BIT + TD) begin
      fails++; $display("FAIL b2b_gap: got %0d clk, required %0d +/- %0d", last_gap, 10 * BIT, TD);
    end
  endtask

  task automatic test_glitch;
    int v0, e0;
    v0 = n_valid;
    e0 = n_err;
    rx = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (rx_busy !== 1'b1) begin fails++; $display("FAIL glitch_start: got busy=%b, required 1", rx_busy); end
    repeat (3 * TD - 6) @(negedge clk);
    rx = 1'b1;
    repeat (BIT) @(negedge clk);
    checks += 3;
    if (rx_busy !== 1'b0) begin fails++; $display("FAIL glitch_busy: got %b, required 0", rx_busy); end
    if (n_valid != v0 || n_err != e0) begin
      fails++; $display("FAIL glitch_strobe: got %0d valid %0d err, required 0 0", n_valid - v0, n_err - e0);
    end
    if (rx_data !== model_data) begin fails++; $display("FAIL glitch_data: got %h, required %h", rx_data, model_data); end
  endtask

  task automatic test_break;
    int v0, e0;
    v0 = n_valid;
    e0 = n_err;
    exp_q.push_back('{err: 1'b1, data: model_data});
    send_frame(9'h0F0, 8, 1'b0, 1'b0);
    repeat (3 * BIT) @(negedge clk);
    checks += 4;
    if (rx_busy !== 1'b1) begin fails++; $display("FAIL break_busy: got %b, required 1", rx_busy); end
    if (n_err - e0 != 1) begin fails++; $display("FAIL break_err_count: got %0d, required 1", n_err - e0); end
    if (n_valid != v0) begin fails++; $display("FAIL break_valid_count: got %0d, required 0", n_valid - v0); end
    if (rx_data !== model_data) begin fails++; $display("FAIL break_data: got %h, required %h", rx_data, model_data); end
    rx = 1'b1;
    repeat (BIT) @(negedge clk);
    checks++;
    if (rx_busy !== 1'b0) begin fails++; $display("FAIL break_release: got busy=%b, required 0", rx_busy); end
    push_good(8'h12);
    send_frame(9'h012, 8, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    checks += 3;
    if (exp_q.size() != 0) begin fails++; $display("FAIL break_pending: got %0d outstanding, required 0", exp_q.size()); end
    if (n_valid - v0 != 1 || n_err - e0 != 1) begin
      fails++; $display("FAIL break_totals: got %0d valid %0d err, required 1 1", n_valid - v0, n_err - e0);
    end
    if (rx_data !== 8'h12) begin fails++; $display("FAIL break_next: got %h, required 12", rx_data); end
  endtask

  task automatic test_reset_mid;
    int v0;
    logic [7:0] d;
    d = 8'h81;
    v0 = n_valid;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i], 1'b0);
    rx = d[4];
    repeat (BIT / 2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks += 4;
    if (rx_data !== 8'h00) begin fails++; $display("FAIL mid_reset_data: got %h, required 00", rx_data); end
    if (rx_valid !== 1'b0) begin fails++; $display("FAIL mid_reset_valid: got %b, required 0", rx_valid); end
    if (frame_err !== 1'b0) begin fails++; $display("FAIL mid_reset_err: got %b, required 0", frame_err); end
    if (rx_busy !== 1'b0) begin fails++; $display("FAIL mid_reset_busy: got %b, required 0", rx_busy); end
    repeat (BIT / 2 - 2) @(negedge clk);
    drive_bit(d[5], 1'b0);
    drive_bit(d[6], 1'b0);
    rx = d[7];
    reset = 1'b0;
    model_data = 8'h00;
    repeat (2 * BIT) @(negedge clk);
    checks += 2;
    if (n_valid != v0) begin fails++; $display("FAIL mid_abandon: got %0d pulses, required 0", n_valid - v0); end
    if (rx_busy !== 1'b0) begin fails++; $display("FAIL mid_idle: got busy=%b, required 0", rx_busy); end
    push_good(8'h7E);
    send_frame(9'h07E, 8, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    checks += 2;
    if (exp_q.size() != 0) begin fails++; $display("FAIL mid_pending: got %0d outstanding, required 0", exp_q.size()); end
    if (rx_data !== 8'h7E) begin fails++; $display("FAIL mid_next: got %h, required 7e", rx_data); end
  endtask

  task automatic test_seven_bits;
    exp7_q.push_back(7'h5A);
    send_frame(9'h05A, 7, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    checks += 3;
    if (exp7_q.size() != 0) begin fails++; $display("FAIL seven_pending: got %0d outstanding, required 0", exp7_q.size()); end
    if (rx_data7 !== 7'h5A) begin fails++; $display("FAIL seven_data: got %h, required 5a", rx_data7); end
    if (rx_busy7 !== 1'b0) begin fails++; $display("FAIL seven_busy: got %b, required 0", rx_busy7); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_break;
    test_reset_mid;
    test_seven_bits;
    repeat (BIT) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL final_pending: got %0d outstanding, required 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
